demux_nibble_1x2: RTL and testbench

- Receiving end of the 2:1 nibble multiplexing path.
- Accepts a time-multiplexed stream of nibbles, qualified by a strobe, and steers them alternately into two registered outputs, D0 first and then D1.
- Signals a complete pair to downstream logic (display or register bank), holds it until acknowledged, and detects a missing second nibble (timeout) and nibbles arriving while a pair is held (overflow).

---
 rtl/demux_nibble_1x2.sv | 150 +++++++++++++++
 tb/tb_demux_nibble_1x2.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_nibble_1x2.sv
// Receiving end of a 2:1 nibble mux: steers strobed nibbles into D0/D1, holds the pair until Ack.
// Optional pair counter output Pares is enabled by defining DEMUX_CONTADOR_EN.
module demux_nibble_1x2 #(
   parameter int unsigned ANCHO   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ANCHO-1:0] Dato,
   input  logic             Valido,
   input  logic             Ack,
   output logic [ANCHO-1:0] D0,
   output logic [ANCHO-1:0] D1,
   output logic             Listo,
   output logic             Error,
   output logic             Desborde
`ifdef DEMUX_CONTADOR_EN
   ,
   output logic [7:0]       Pares
`endif
);

   localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_D0    = 2'd0,
      S_D1    = 2'd1,
      S_LLENO = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ANCHO-1:0] d0_q, d0_d;
   logic [ANCHO-1:0] d1_q, d1_d;
   logic             listo_q, listo_d;
   logic             error_q, error_d;
   logic             desb_q, desb_d;
`ifdef DEMUX_CONTADOR_EN
   logic [7:0]       pares_q, pares_d;
`endif

   // The idle counter has seen TIMEOUT-1 empty cycles; one more idle edge expires the pair.
   logic cnt_expira;
   assign cnt_expira = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_D0;
         cnt_q   <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         listo_q <= 1'b0;
         error_q <= 1'b0;
         desb_q  <= 1'b0;
`ifdef DEMUX_CONTADOR_EN
         pares_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         listo_q <= listo_d;
         error_q <= error_d;
         desb_q  <= desb_d;
`ifdef DEMUX_CONTADOR_EN
         pares_q <= pares_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_D0: begin
            if (Valido) state_d = S_D1;
         end
         S_D1: begin
            if (Valido)          state_d = S_LLENO;
            else if (cnt_expira) state_d = S_D0;
         end
         S_LLENO: begin
            if (Ack) state_d = Valido ? S_D1 : S_D0;
         end
         default: state_d = S_D0;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      listo_d = listo_q;
      error_d = 1'b0;
      desb_d  = 1'b0;
`ifdef DEMUX_CONTADOR_EN
      pares_d = pares_q;
`endif
      case (state_q)
         S_D0: begin
            if (Valido) begin
               d0_d  = Dato;
               cnt_d = '0;
            end
         end
         S_D1: begin
            // A capture on the expiry edge takes priority over the timeout.
            if (Valido) begin
               d1_d    = Dato;
               listo_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_expira) begin
               error_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_LLENO: begin
            if (Ack) begin
               listo_d = 1'b0;
`ifdef DEMUX_CONTADOR_EN
               pares_d = pares_q + 8'd1;
`endif
               if (Valido) begin
                  d0_d  = Dato;
                  cnt_d = '0;
               end
            end else if (Valido) begin
               desb_d = 1'b1;
            end
         end
         default: begin
            listo_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign D0       = d0_q;
   assign D1       = d1_q;
   assign Listo    = listo_q;
   assign Error    = error_q;
   assign Desborde = desb_q;
`ifdef DEMUX_CONTADOR_EN
   assign Pares    = pares_q;
`endif

endmodule

// File: tb/tb_demux_nibble_1x2.sv
// Scoreboard bench for demux_nibble_1x2: expected pairs are queued at stimulus time and
// compared when Listo rises; direct checks cover pulses, holding, timeout and reset.
module tb_demux_nibble_1x2;

   localparam int unsigned ANCHO   = 4;
   localparam int unsigned TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [ANCHO-1:0] Dato;
   logic             Valido;
   logic             Ack;
   logic [ANCHO-1:0] D0;
   logic [ANCHO-1:0] D1;
   logic             Listo;
   logic             Error;
   logic             Desborde;
`ifdef DEMUX_CONTADOR_EN
   logic [7:0]       Pares;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  exp_q[$];
   logic        listo_prev = 1'b0;

   demux_nibble_1x2 #(.ANCHO(ANCHO), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .Dato     (Dato),
      .Valido   (Valido),
      .Ack      (Ack),
      .D0       (D0),
      .D1       (D1),
      .Listo    (Listo),
      .Error    (Error),
      .Desborde (Desborde)
`ifdef DEMUX_CONTADOR_EN
      ,
      .Pares    (Pares)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, return just after it.
   task automatic step(input logic v, input logic [ANCHO-1:0] d, input logic a);
      Valido = v;
      Dato   = d;
      Ack    = a;
      @(posedge clk);
      #1;
      Valido = 1'b0;
      Dato   = '0;
      Ack    = 1'b0;
   endtask

   task automatic push_pair(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
      exp_q.push_back({a, b});
   endtask

   always @(negedge clk) begin
      listo_prev <= Listo;
      if (reset_n && Listo && !listo_prev) begin
         if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("sb_pair", {24'd0, D0, D1}, {24'd0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      Dato    = '0;
      Valido  = 1'b0;
      Ack     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_D0", D0, 0);
      check("rst_D1", D1, 0);
      check("rst_Listo", Listo, 0);
      check("rst_Error", Error, 0);
      check("rst_Desborde", Desborde, 0);
`ifdef DEMUX_CONTADOR_EN
      check("rst_Pares", Pares, 0);
`endif
      reset_n = 1'b1;
      step(1'b0, 4'h0, 1'b0);

      // Basic pair, held without Ack, then released
      step(1'b1, 4'hA, 1'b0);
      check("t1_D0", D0, 4'hA);
      check("t1_Listo_early", Listo, 0);
      push_pair(4'hA, 4'h5);
      step(1'b1, 4'h5, 1'b0);
      check("t1_Listo", Listo, 1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'h0, 1'b0);
         check("t1_hold_Listo", Listo, 1);
         check("t1_hold_D0", D0, 4'hA);
         check("t1_hold_D1", D1, 4'h5);
      end
      step(1'b0, 4'h0, 1'b1);
      check("t1_ack_Listo", Listo, 0);

      // Timeout after TIMEOUT idle edges
      step(1'b1, 4'h3, 1'b0);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step(1'b0, 4'h0, 1'b0);
         check("t2_no_early_Error", Error, 0);
      end
      step(1'b0, 4'h0, 1'b0);
      check("t2_Error", Error, 1);
      check("t2_D0_kept", D0, 4'h3);
      check("t2_Listo", Listo, 0);
      step(1'b0, 4'h0, 1'b0);
      check("t2_Error_pulse", Error, 0);
      step(1'b0, 4'h0, 1'b0);
      check("t2_idle_Error", Error, 0);
      check("t2_idle_Listo", Listo, 0);

      // Capture on the expiry edge wins over the timeout
      step(1'b1, 4'h3, 1'b0);
      for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 4'h0, 1'b0);
      push_pair(4'h3, 4'h9);
      step(1'b1, 4'h9, 1'b0);
      check("t2b_Error", Error, 0);
      check("t2b_D1", D1, 4'h9);
      check("t2b_Listo", Listo, 1);
      step(1'b0, 4'h0, 1'b0);
      check("t2b_Error_after", Error, 0);
      step(1'b0, 4'h0, 1'b1);
      check("t2b_ack", Listo, 0);

      // Overflow while a pair is held
      step(1'b1, 4'h1, 1'b0);
      push_pair(4'h1, 4'h2);
      step(1'b1, 4'h2, 1'b0);
      check("t3_Desborde_before", Desborde, 0);
      step(1'b1, 4'hF, 1'b0);
      check("t3_Desborde", Desborde, 1);
      check("t3_D0", D0, 4'h1);
      check("t3_D1", D1, 4'h2);
      check("t3_Listo", Listo, 1);
      step(1'b0, 4'h0, 1'b0);
      check("t3_Desborde_pulse", Desborde, 0);
      check("t3_Listo_held", Listo, 1);

      // Zero-bubble Ack plus new first nibble
      step(1'b1, 4'h7, 1'b1);
      check("t4_Listo", Listo, 0);
      check("t4_D0", D0, 4'h7);
      check("t4_Desborde", Desborde, 0);
      push_pair(4'h7, 4'h8);
      step(1'b1, 4'h8, 1'b0);
      check("t4_Listo2", Listo, 1);
      check("t4_D1", D1, 4'h8);
      step(1'b0, 4'h0, 1'b1);
      check("t4_ack", Listo, 0);

      // Asynchronous reset in the middle of a pair
      step(1'b1, 4'h6, 1'b0);
      check("t5_D0_pre", D0, 4'h6);
      #3;
      reset_n = 1'b0;
      #1;
      check("t5_D0", D0, 0);
      check("t5_D1", D1, 0);
      check("t5_Listo", Listo, 0);
      check("t5_Error", Error, 0);
      check("t5_Desborde", Desborde, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b1, 4'hC, 1'b0);
      push_pair(4'hC, 4'hD);
      step(1'b1, 4'hD, 1'b0);
      check("t5_Listo_after", Listo, 1);
      check("t5_D0_after", D0, 4'hC);
      check("t5_D1_after", D1, 4'hD);
      step(1'b0, 4'h0, 1'b1);
      check("t5_ack", Listo, 0);

`ifdef DEMUX_CONTADOR_EN
      // Pair counter: one Ack since the reset, add two more, then wrap at 256
      check("t6_Pares_1", Pares, 1);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 4'(i), 1'b0);
         push_pair(4'(i), 4'(i + 8));
         step(1'b1, 4'(i + 8), 1'b0);
         step(1'b0, 4'h0, 1'b1);
      end
      check("t6_Pares_3", Pares, 3);
      for (int i = 0; i < 253; i++) begin
         step(1'b1, 4'(i), 1'b0);
         push_pair(4'(i), 4'(i + 3));
         step(1'b1, 4'(i + 3), 1'b0);
         step(1'b0, 4'h0, 1'b1);
      end
      check("t6_Pares_wrap", Pares, 0);
`endif

      step(1'b0, 4'h0, 1'b0);
      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
